// File: rtl/fifo36k_pkg.sv
// Shared constants, flag bundle and helpers for the 36 Kb synchronous FIFO.
package fifo36k_pkg;

    localparam int unsigned DATA_WIDTH        = 36;
    localparam int unsigned DEPTH             = 1024;
    localparam int unsigned ADDR_W            = 10;
    localparam int unsigned CNT_W             = 11;
    localparam int unsigned PROG_EMPTY_THRESH = 4;
    localparam int unsigned PROG_FULL_THRESH  = 1018;

    // Occupancy-derived status flags, all registered together.
    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
        logic prog_empty;
        logic prog_full;
    } flags_t;

    // Reset value: empty and prog_empty set, everything else clear.
    localparam flags_t FLAGS_RESET = '{
        empty:        1'b1,
        full:         1'b0,
        almost_empty: 1'b0,
        almost_full:  1'b0,
        prog_empty:   1'b1,
        prog_full:    1'b0
    };

    // Pointer increment with explicit wrap at the last entry.
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] ptr,
                                                  input int unsigned      depth);
        if (32'(ptr) == depth - 1) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    // Decode the status flags from an occupancy count.
    function automatic flags_t calc_flags(input logic [CNT_W-1:0] cnt,
                                          input int unsigned     depth,
                                          input int unsigned     pe_thresh,
                                          input int unsigned     pf_thresh);
        flags_t f;
        f.empty        = (cnt == '0);
        f.full         = (32'(cnt) == depth);
        f.almost_empty = (32'(cnt) == 32'd1);
        f.almost_full  = (32'(cnt) == depth - 1);
        f.prog_empty   = (32'(cnt) <= pe_thresh);
        f.prog_full    = (32'(cnt) >= pf_thresh);
        return f;
    endfunction

endpackage

// File: rtl/fifo36k_ram.sv
// Simple dual-port RAM: synchronous write port, registered synchronous read port.
// Only the read register is reset; the array itself keeps its contents.
module fifo36k_ram
    import fifo36k_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH,
    parameter int unsigned AW    = ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [2**AW];

    // Write port: store the word at the addressed entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: output register loads only on a read, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo36k_synch_primitive.sv
// Single-clock 1024x36 standard-mode FIFO with registered status and error flags.
module fifo36k_synch_primitive #(
    parameter int unsigned DATA_WIDTH        = fifo36k_pkg::DATA_WIDTH,
    parameter int unsigned DEPTH             = fifo36k_pkg::DEPTH,
    parameter int unsigned PROG_EMPTY_THRESH = fifo36k_pkg::PROG_EMPTY_THRESH,
    parameter int unsigned PROG_FULL_THRESH  = fifo36k_pkg::PROG_FULL_THRESH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] push,
    output logic [DATA_WIDTH-1:0] pop,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  prog_empty,
    output logic                  prog_full,
    output logic                  overflow,
    output logic                  underflow
);
    import fifo36k_pkg::*;

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    flags_t            flags_q, flags_d;
    logic              overflow_q, underflow_q;
    logic              wr_ok, rd_ok;

    // Accept decisions use the registered flags, so a write into an empty FIFO
    // and a read out of a full one are always legal in the same cycle.
    always_comb begin
        wr_ok   = wr_en && !flags_q.full;
        rd_ok   = rd_en && !flags_q.empty;
        wptr_d  = wr_ok ? ptr_inc(wptr_q, DEPTH) : wptr_q;
        rptr_d  = rd_ok ? ptr_inc(rptr_q, DEPTH) : rptr_q;
        count_d = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        flags_d = calc_flags(count_d, DEPTH, PROG_EMPTY_THRESH, PROG_FULL_THRESH);
    end

    // Pointer, count, flag and error-pulse registers; reset wins over requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            flags_q     <= FLAGS_RESET;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            flags_q     <= flags_d;
            overflow_q  <= wr_en && flags_q.full;
            underflow_q <= rd_en && flags_q.empty;
        end
    end

    // Full and empty never coincide, so write and read addresses cannot collide.
    fifo36k_ram #(
        .WIDTH (DATA_WIDTH),
        .AW    (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok && !rst),
        .wr_addr (wptr_q),
        .wr_data (push),
        .rd_en   (rd_ok && !rst),
        .rd_addr (rptr_q),
        .rd_data (pop)
    );

    assign empty        = flags_q.empty;
    assign full         = flags_q.full;
    assign almost_empty = flags_q.almost_empty;
    assign almost_full  = flags_q.almost_full;
    assign prog_empty   = flags_q.prog_empty;
    assign prog_full    = flags_q.prog_full;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo36k_synch_primitive.sv
// Bench for fifo36k_synch_primitive: fixed vector table, directed corner sequences
// and random traffic, all checked against a queue-based reference model.
module tb_fifo36k_synch_primitive;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [35:0] push = '0;
    logic [35:0] pop;
    logic        empty, full, almost_empty, almost_full;
    logic        prog_empty, prog_full, overflow, underflow;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents as a queue plus the last popped word.
    logic [35:0] mq[$];
    logic [35:0] m_pop = '0;
    bit          m_ovf = 1'b0;
    bit          m_unf = 1'b0;

    always #5 clk = ~clk;

    fifo36k_synch_primitive dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .push         (push),
        .pop          (pop),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .prog_empty   (prog_empty),
        .prog_full    (prog_full),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    typedef struct {
        bit          r;
        bit          w;
        bit          rd;
        logic [35:0] d;
        logic [35:0] e_pop;
        logic [7:0]  e_flags; // {empty,full,aempty,afull,pempty,pfull,ovf,unf}
    } vec_t;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] dut_flags();
        return {empty, full, almost_empty, almost_full, prog_empty, prog_full,
                overflow, underflow};
    endfunction

    function automatic logic [7:0] model_flags();
        int n = mq.size();
        return {n == 0, n == 1024, n == 1, n == 1023, n <= 4, n >= 1018, m_ovf, m_unf};
    endfunction

    function automatic logic [35:0] rand36();
        return {4'($urandom), $urandom};
    endfunction

    // One clock: update the model, drive inputs, sample #1 after the edge, compare.
    task automatic step(input bit r, input bit w, input bit rd, input logic [35:0] d,
                        input string tag);
        bit was_full  = (mq.size() == 1024);
        bit was_empty = (mq.size() == 0);
        if (r) begin
            mq.delete();
            m_pop = '0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            m_ovf = w && was_full;
            m_unf = rd && was_empty;
            if (rd && !was_empty) m_pop = mq.pop_front();
            if (w && !was_full) mq.push_back(d);
        end
        rst   = r;
        wr_en = w;
        rd_en = rd;
        push  = d;
        @(posedge clk);
        #1;
        check({tag, "_pop"}, pop, m_pop);
        check({tag, "_flags"}, 36'(dut_flags()), 36'(model_flags()));
    endtask

    initial begin
        vec_t vt[13];
        int   n;

        // Reset held for five cycles, then compare against the spec reset values.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, '0, "reset");
        check("reset_pop_zero", pop, 36'h0);
        check("reset_flags", 36'(dut_flags()), 36'(8'b1000_1000));

        // Short hand-derived vector table covering latency, hold and reset priority.
        vt[0]  = '{1, 0, 0, 36'h0,   36'h0,   8'b1000_1000};
        vt[1]  = '{0, 0, 1, 36'h0,   36'h0,   8'b1000_1001};
        vt[2]  = '{0, 1, 0, 36'h111, 36'h0,   8'b0010_1000};
        vt[3]  = '{0, 1, 0, 36'h222, 36'h0,   8'b0000_1000};
        vt[4]  = '{0, 0, 1, 36'h0,   36'h111, 8'b0010_1000};
        vt[5]  = '{0, 1, 1, 36'h333, 36'h222, 8'b0010_1000};
        vt[6]  = '{0, 0, 1, 36'h0,   36'h333, 8'b1000_1000};
        vt[7]  = '{0, 0, 0, 36'h0,   36'h333, 8'b1000_1000};
        vt[8]  = '{0, 1, 1, 36'h444, 36'h333, 8'b0010_1001};
        vt[9]  = '{0, 0, 1, 36'h0,   36'h444, 8'b1000_1000};
        vt[10] = '{1, 1, 0, 36'h555, 36'h0,   8'b1000_1000};
        vt[11] = '{0, 1, 0, 36'h666, 36'h0,   8'b0010_1000};
        vt[12] = '{0, 0, 1, 36'h0,   36'h666, 8'b1000_1000};
        for (int i = 0; i < 13; i++) begin
            step(vt[i].r, vt[i].w, vt[i].rd, vt[i].d, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_tpop", i), pop, vt[i].e_pop);
            check($sformatf("vec%0d_tflags", i), 36'(dut_flags()), 36'(vt[i].e_flags));
        end

        // Fill 1000 random words, then drain them in order.
        step(1'b1, 1'b0, 1'b0, '0, "fd_rst");
        for (int i = 0; i < 1000; i++) step(1'b0, 1'b1, 1'b0, rand36(), "fill");
        for (int i = 0; i < 1000; i++) step(1'b0, 1'b0, 1'b1, '0, "drain");
        check("drain_empty", 36'(empty), 36'h1);

        // Boundaries: fill to full, overflow attempt, then drain past empty.
        step(1'b1, 1'b0, 1'b0, '0, "bnd_rst");
        for (int i = 0; i < 1024; i++) begin
            step(1'b0, 1'b1, 1'b0, rand36(), "bfill");
            if (i == 1016) check("pfull_below", 36'(prog_full), 36'h0);
            if (i == 1017) check("pfull_at_1018", 36'(prog_full), 36'h1);
            if (i == 1022) check("afull_at_1023", 36'({almost_full, full}), 36'h2);
        end
        check("full_at_1024", 36'({almost_full, full}), 36'h1);
        step(1'b0, 1'b1, 1'b0, 36'hBAD_BAD_BAD, "ovf");
        check("ovf_pulse", 36'(overflow), 36'h1);
        step(1'b0, 1'b0, 1'b0, '0, "ovf_clr");
        check("ovf_cleared", 36'(overflow), 36'h0);
        for (int i = 0; i < 1024; i++) step(1'b0, 1'b0, 1'b1, '0, "bdrain");
        step(1'b0, 1'b0, 1'b1, '0, "unf");
        check("unf_pulse", 36'(underflow), 36'h1);
        step(1'b0, 1'b0, 1'b0, '0, "unf_clr");
        check("unf_cleared", 36'(underflow), 36'h0);

        // Simultaneous read/write at count 5, at full and at empty.
        step(1'b1, 1'b0, 1'b0, '0, "sim_rst");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, rand36(), "sim_fill5");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, rand36(), "sim_mid");
        for (int i = 0; i < 1019; i++) step(1'b0, 1'b1, 1'b0, rand36(), "sim_fillf");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, rand36(), "sim_full");
        n = mq.size();
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, '0, "sim_drain");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, rand36(), "sim_empty");

        // Random traffic with phase-varying write/read bias and rare resets.
        for (int ph = 0; ph < 4; ph++) begin
            int wp = (ph % 2 == 0) ? 75 : 30;
            for (int i = 0; i < 800; i++) begin
                bit r = ($urandom_range(0, 499) == 0);
                bit w = ($urandom_range(0, 99) < wp);
                bit rd = ($urandom_range(0, 99) < 100 - wp + 10);
                step(r, w, rd, rand36(), "rand");
            end
        end

        // Mid-operation reset followed by a single write/read.
        step(1'b1, 1'b0, 1'b0, '0, "mid_rst0");
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0, rand36(), "mid_fill");
        step(1'b1, 1'b0, 1'b0, '0, "mid_rst");
        check("mid_rst_empty", 36'(empty), 36'h1);
        step(1'b0, 1'b1, 1'b0, 36'hA5A5A5A5A, "mid_wr");
        step(1'b0, 1'b0, 1'b1, '0, "mid_rd");
        check("mid_rd_value", pop, 36'hA5A5A5A5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
